// File: rtl/stopwatch_pkg.sv
// Shared constants for the lap stopwatch: FSM state encodings, BCD digit sizing
// and the decoded button command.
package stopwatch_pkg;

    localparam logic [1:0] ST_IDLE    = 2'b00;
    localparam logic [1:0] ST_RUNNING = 2'b01;
    localparam logic [1:0] ST_STOPPED = 2'b10;
    localparam logic [1:0] ST_LAP     = 2'b11;

    localparam int unsigned DIGIT_W   = 4;
    localparam logic [3:0]  DIGIT_MAX = 4'd9;

    // Highest-priority button pulse seen on a given cycle.
    typedef enum logic [2:0] {
        CMD_NONE,
        CMD_CLEAR,
        CMD_STOP,
        CMD_START,
        CMD_LAP
    } cmd_t;

endpackage

// File: rtl/button_edge.sv
// Two-flop synchroniser for an asynchronous button level followed by a
// registered rising-edge detector: one press yields one single-cycle pulse.
module button_edge (
    input  logic clock,
    input  logic reset,
    input  logic level,
    output logic pulse
);

    logic [1:0] sync;
    logic       prev;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync  <= 2'b00;
            prev  <= 1'b0;
            pulse <= 1'b0;
        end else begin
            sync  <= {sync[0], level};
            prev  <= sync[1];
            pulse <= sync[1] & ~prev;
        end
    end

endmodule

// File: rtl/lap_stopwatch.sv
// BCD stopwatch core with internal tick divider, start/stop/clear control and
// optional lap freeze (enabled by defining LAP_STOPWATCH_LAP_EN).
module lap_stopwatch
    import stopwatch_pkg::*;
#(
    parameter int unsigned CLK_HZ  = 50_000_000,
    parameter int unsigned TICK_HZ = 100,
    parameter int unsigned DIGITS  = 4
) (
    input  logic                        clock,
    input  logic                        reset,
    input  logic                        start_button,
    input  logic                        stop_button,
    input  logic                        clear_button,
    input  logic                        lap_button,
    output logic [DIGIT_W*DIGITS-1:0]   digits,
    output logic [1:0]                  state,
    output logic                        running,
    output logic                        overflow,
    output logic                        tick
);

    localparam int unsigned DIV   = CLK_HZ / TICK_HZ;
    localparam int unsigned DIV_W = $clog2(DIV);
    localparam int unsigned CNT_W = DIGIT_W * DIGITS;

    logic [DIV_W-1:0] div_cnt;
    logic [DIV_W-1:0] div_nxt;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_nxt;
    logic [CNT_W-1:0] count_inc;
    logic [CNT_W-1:0] disp_nxt;
    logic [1:0]       state_nxt;
    logic             ovf_nxt;
    logic             carry;
    logic             start_p;
    logic             stop_p;
    logic             clear_p;
    logic             lap_p;
    cmd_t             cmd;

    button_edge u_start (.clock(clock), .reset(reset), .level(start_button), .pulse(start_p));
    button_edge u_stop  (.clock(clock), .reset(reset), .level(stop_button),  .pulse(stop_p));
    button_edge u_clear (.clock(clock), .reset(reset), .level(clear_button), .pulse(clear_p));

`ifdef LAP_STOPWATCH_LAP_EN
    button_edge u_lap   (.clock(clock), .reset(reset), .level(lap_button),   .pulse(lap_p));
`else
    logic lap_unused;
    assign lap_unused = lap_button;
    assign lap_p      = 1'b0;
`endif

    // Free-running tick divider; tick is registered so it is high while div_cnt is terminal.
    assign div_nxt = (div_cnt == DIV_W'(DIV - 1)) ? '0 : div_cnt + DIV_W'(1);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            div_cnt <= '0;
            tick    <= 1'b0;
        end else begin
            div_cnt <= div_nxt;
            tick    <= (div_nxt == DIV_W'(DIV - 1));
        end
    end

    // Only the highest-priority pulse is considered; if it is illegal in the state it is dropped.
    always_comb begin
        cmd = CMD_NONE;
        if (clear_p)      cmd = CMD_CLEAR;
        else if (stop_p)  cmd = CMD_STOP;
        else if (start_p) cmd = CMD_START;
        else if (lap_p)   cmd = CMD_LAP;
    end

    // Ripple BCD increment; carry out of the top digit marks the all-9s wrap.
    always_comb begin
        count_inc = count;
        carry     = 1'b1;
        for (int i = 0; i < int'(DIGITS); i++) begin
            if (carry) begin
                if (count[i*DIGIT_W +: DIGIT_W] == DIGIT_MAX) begin
                    count_inc[i*DIGIT_W +: DIGIT_W] = '0;
                end else begin
                    count_inc[i*DIGIT_W +: DIGIT_W] = count[i*DIGIT_W +: DIGIT_W] + DIGIT_W'(1);
                    carry = 1'b0;
                end
            end
        end
    end

    // Next state and counter; the increment is gated by the pre-transition state.
    always_comb begin
        state_nxt = state;
        count_nxt = count;
        ovf_nxt   = overflow;
        if (tick && (state == ST_RUNNING || state == ST_LAP)) begin
            count_nxt = count_inc;
            if (carry) ovf_nxt = 1'b1;
        end
        case (state)
            ST_IDLE: begin
                if (cmd == CMD_START) state_nxt = ST_RUNNING;
            end
            ST_RUNNING: begin
                if (cmd == CMD_STOP)     state_nxt = ST_STOPPED;
`ifdef LAP_STOPWATCH_LAP_EN
                else if (cmd == CMD_LAP) state_nxt = ST_LAP;
`endif
            end
            ST_STOPPED: begin
                if (cmd == CMD_CLEAR) begin
                    state_nxt = ST_IDLE;
                    count_nxt = '0;
                    ovf_nxt   = 1'b0;
                end else if (cmd == CMD_START) begin
                    state_nxt = ST_RUNNING;
                end
            end
`ifdef LAP_STOPWATCH_LAP_EN
            ST_LAP: begin
                if (cmd == CMD_STOP)       state_nxt = ST_STOPPED;
                else if (cmd == CMD_START) state_nxt = ST_RUNNING;
            end
`endif
            default: state_nxt = ST_IDLE;
        endcase
    end

`ifdef LAP_STOPWATCH_LAP_EN
    logic [CNT_W-1:0] lap_reg;
    logic [CNT_W-1:0] lap_nxt;

    // Lap latch takes the pre-edge count, so a same-edge increment is excluded.
    always_comb begin
        lap_nxt = lap_reg;
        if ((state == ST_RUNNING || state == ST_LAP) && cmd == CMD_LAP) lap_nxt = count;
        if (state == ST_STOPPED && cmd == CMD_CLEAR)                    lap_nxt = '0;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) lap_reg <= '0;
        else       lap_reg <= lap_nxt;
    end

    assign disp_nxt = (state_nxt == ST_LAP) ? lap_nxt : count_nxt;
`else
    assign disp_nxt = count_nxt;
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state    <= ST_IDLE;
            count    <= '0;
            overflow <= 1'b0;
            digits   <= '0;
            running  <= 1'b0;
        end else begin
            state    <= state_nxt;
            count    <= count_nxt;
            overflow <= ovf_nxt;
            digits   <= disp_nxt;
            running  <= (state_nxt == ST_RUNNING) || (state_nxt == ST_LAP);
        end
    end

endmodule
